ocx_dlx_rx_retrain_ctl: RTL
===========================

Name: ocx_dlx_rx_retrain_ctl

Overview:
Sequences the GTY receiver bring-up and retrain for one 8-lane DLx link. Waits for PHY RX reset completion, then for sync on all lanes. Issues a fixed-width rx datapath reset to re-centre the eye, releases rx_init_done to the DLx, and supervises the running link. Retries the sequence on sync timeout or lane loss, bounded by a retry limit, and latches a failure. Sits between the DLx training logic and the Xilinx transceiver wizard reset inputs.

Parameters:
PULSE_LEN, 8, cycles rx_datapath_reset is held high (min 1, max 2^TMR_W-1)
TMR_W, 20, width of the shared state timer
SYNC_TIMEOUT, 20'd1000000, cycles allowed in WAIT_SYNC before retry
DONE_TIMEOUT, 20'd65535, cycles allowed in WAIT_DONE before FAIL
MAX_RETRY, 3, retry events tolerated before FAIL (1..15)
LOSS_CYCLES, 16, consecutive cycles of any lane invalid that declare lane loss

Ports:
opt_gckn  in  1  sole clock (DLx RX clock domain)
dlx_reset_n  in  1  asynchronous, active-low reset
enable  in  1  start/hold training; low requests return to IDLE
rx_run_lane  in  8  per-lane sync-detected from DLx
rx_reset_done  in  1  gtwiz_reset_rx_done AND gtwiz_buffbypass_rx_done, pre-combined
rx_valid  in  8  per-lane rx valid (already qualified by PHY init)
link_up  in  1  DLx training complete
rx_datapath_reset  out  1  to gtwiz_reset_rx_datapath
rx_init_done  out  8  to DLx io_pb_o0_rx_init_done
retrain_cnt  out  4  saturating count of retrain events since reset
fail  out  1  retry limit exhausted or reset-done timeout
busy  out  1  state not IDLE, RUN or FAIL
state  out  3  current FSM state encoding, debug

Behaviour:
- Reset (async assert, sync deassert by the top level): state=IDLE, all outputs 0, timer=0, attempt=0, loss counter=0, synced=0, seen_low=0.
- States: IDLE=0, WAIT_PHY=1, WAIT_SYNC=2, PULSE=3, WAIT_DONE=4, RUN=5, FAIL=6; 7 is illegal and goes to IDLE.
- Timer: TMR_W bits. Cleared on every state change, otherwise +1. Saturates, never wraps.
- IDLE: enable=1 -> WAIT_PHY; attempt cleared to 0.
- WAIT_PHY: rx_reset_done=1 -> WAIT_SYNC.
- WAIT_SYNC:
  - &rx_run_lane=1 -> PULSE with synced=1.
  - Otherwise, timer==SYNC_TIMEOUT-1 is a retry event -> PULSE with synced=0.
- PULSE: rx_datapath_reset=1 for exactly PULSE_LEN cycles (registered output), then -> WAIT_DONE with seen_low=0.
- WAIT_DONE:
  - seen_low is set when rx_reset_done=0.
  - seen_low=1 and rx_reset_done=1 -> RUN if synced, else WAIT_SYNC.
  - timer==DONE_TIMEOUT-1 -> FAIL.
- RUN:
  - rx_init_done={8{rx_reset_done}}, registered.
  - Loss counter increments while any rx_valid bit is 0 and clears when all are 1.
  - Loss counter reaching LOSS_CYCLES-1, or rx_reset_done=0, is a retry event -> WAIT_PHY with synced=0.
  - link_up=1 clears attempt to 0. This is a successful train; it does not change state.
- Retry event:
  - If attempt==MAX_RETRY -> FAIL instead of the retry target.
  - Otherwise attempt+1.
  - retrain_cnt+1, saturating at 15. retrain_cnt clears only on reset.
- FAIL: fail=1; enable=0 -> IDLE. fail clears on leaving FAIL.
- enable=0:
  - In any state except PULSE: -> IDLE next cycle.
  - In PULSE: the pulse completes its full width first (no truncated PHY resets), then -> IDLE.
- Simultaneous events:
  - enable=0 has priority over all other transitions, except in PULSE.
  - In WAIT_SYNC, sync beats timeout on the same cycle.
  - In RUN, a retry event beats link_up.
- rx_init_done is 0 in every state other than RUN.
- busy and state are registered, consistent with the state register.

Decomposition:
- Shared package ocx_dlx_pkg: state encodings (3-bit localparams) and the 8-lane width constant.
- No sub-module. The timer, the loss counter and the FSM all live in one file, about 200 lines.

Test Plan:
- Nominal bring-up: enable=1, rx_reset_done rises at cycle 10, rx_run_lane=8'hFF at 50 -> rx_datapath_reset high exactly 8 cycles. After rx_reset_done falls and rises, state=RUN and rx_init_done=8'hFF. retrain_cnt=0.
- Sync timeout with SYNC_TIMEOUT=100, lane 3 never syncs -> pulse at 100 cycles. Return to WAIT_SYNC; after the 4th timeout, fail=1, retrain_cnt=3, state=6.
- Lane loss in RUN: rx_valid=8'hFE for 15 cycles -> stays RUN. Then 16 cycles -> WAIT_PHY, retrain_cnt+1, rx_init_done=0 next cycle.
- link_up clears attempts: 3 lane losses with link_up pulses between them -> no FAIL. A 4th loss without link_up -> still a retry; fail=0.
- enable dropped in cycle 2 of PULSE -> rx_datapath_reset stays high all 8 cycles, then state=IDLE.
- Async reset asserted mid-PULSE -> rx_datapath_reset=0 immediately (same cycle, no clock edge), all outputs 0, retrain_cnt=0.

Source files
------------

// File: rtl/ocx_dlx_pkg.sv
// Shared definitions for the DLx receive-side link control logic.
package ocx_dlx_pkg;

   // Lanes per DLx link
   localparam int LANES = 8;

   // Retrain sequencer state encodings (3'd7 is unused and recovers to IDLE)
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_PHY  = 3'd1,
      ST_WAIT_SYNC = 3'd2,
      ST_PULSE     = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_RUN       = 3'd5,
      ST_FAIL      = 3'd6
   } state_t;

   // True for the transient bring-up states (everything except IDLE, RUN, FAIL)
   function automatic logic is_busy(input state_t s);
      return (s == ST_WAIT_PHY) || (s == ST_WAIT_SYNC) ||
             (s == ST_PULSE)    || (s == ST_WAIT_DONE);
   endfunction

endpackage

// File: rtl/ocx_dlx_rx_retrain_ctl.sv
// GTY receiver bring-up / retrain sequencer for one 8-lane DLx link.
// Waits for PHY reset done, lane sync, pulses the rx datapath reset,
// then supervises the running link and retries on timeout or lane loss.
module ocx_dlx_rx_retrain_ctl
   import ocx_dlx_pkg::*;
#(
   parameter int                PULSE_LEN    = 8,
   parameter int                TMR_W        = 20,
   parameter logic [TMR_W-1:0]  SYNC_TIMEOUT = 20'd1000000,
   parameter logic [TMR_W-1:0]  DONE_TIMEOUT = 20'd65535,
   parameter int                MAX_RETRY    = 3,
   parameter int                LOSS_CYCLES  = 16
) (
   input  logic             opt_gckn,
   input  logic             dlx_reset_n,
   input  logic             enable,
   input  logic [LANES-1:0] rx_run_lane,
   input  logic             rx_reset_done,
   input  logic [LANES-1:0] rx_valid,
   input  logic             link_up,
   output logic             rx_datapath_reset,
   output logic [LANES-1:0] rx_init_done,
   output logic [3:0]       retrain_cnt,
   output logic             fail,
   output logic             busy,
   output logic [2:0]       state
);

   localparam int               LOSS_W     = $clog2(LOSS_CYCLES + 1);
   localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_LEN - 1);
   localparam logic [TMR_W-1:0] SYNC_LAST  = SYNC_TIMEOUT - 1'b1;
   localparam logic [TMR_W-1:0] DONE_LAST  = DONE_TIMEOUT - 1'b1;
   localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_CYCLES - 1);
   localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRY);

   state_t              r_state;
   state_t              w_state_next;
   logic [TMR_W-1:0]    r_timer;
   logic [LOSS_W-1:0]   r_loss;
   logic [3:0]          r_attempt;
   logic [3:0]          r_retrain_cnt;
   logic                r_synced;
   logic                r_seen_low;
   logic                r_abort;
   logic                r_dp_reset;
   logic [LANES-1:0]    r_init_done;
   logic                r_fail;
   logic                r_busy;

   logic                w_retry;
   logic                w_set_synced;
   logic                w_clr_synced;
   logic                w_link_ok;
   logic                w_at_max;
   logic                w_loss;
   logic                w_sync_all;

   assign w_at_max   = (r_attempt == RETRY_MAX);
   assign w_sync_all = &rx_run_lane;
   // Loss is declared on the LOSS_CYCLES-th consecutive cycle with a bad lane
   assign w_loss     = ~(&rx_valid) && (r_loss == LOSS_LAST);

   // Next-state decode; enable=0 wins everywhere except mid-pulse
   always_comb begin
      w_state_next = r_state;
      w_retry      = 1'b0;
      w_set_synced = 1'b0;
      w_clr_synced = 1'b0;
      w_link_ok    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable) w_state_next = ST_WAIT_PHY;
         end
         ST_WAIT_PHY: begin
            if (!enable)           w_state_next = ST_IDLE;
            else if (rx_reset_done) w_state_next = ST_WAIT_SYNC;
         end
         ST_WAIT_SYNC: begin
            if (!enable) begin
               w_state_next = ST_IDLE;
            end else if (w_sync_all) begin
               w_state_next = ST_PULSE;
               w_set_synced = 1'b1;
            end else if (r_timer == SYNC_LAST) begin
               w_retry      = 1'b1;
               w_clr_synced = 1'b1;
               w_state_next = w_at_max ? ST_FAIL : ST_PULSE;
            end
         end
         ST_PULSE: begin
            // Never truncate a PHY reset; an abort only takes effect at the end
            if (r_timer == PULSE_LAST)
               w_state_next = (r_abort || !enable) ? ST_IDLE : ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (!enable)
               w_state_next = ST_IDLE;
            else if (r_seen_low && rx_reset_done)
               w_state_next = r_synced ? ST_RUN : ST_WAIT_SYNC;
            else if (r_timer == DONE_LAST)
               w_state_next = ST_FAIL;
         end
         ST_RUN: begin
            if (!enable) begin
               w_state_next = ST_IDLE;
            end else if (w_loss || !rx_reset_done) begin
               w_retry      = 1'b1;
               w_clr_synced = 1'b1;
               w_state_next = w_at_max ? ST_FAIL : ST_WAIT_PHY;
            end else if (link_up) begin
               w_link_ok = 1'b1;
            end
         end
         ST_FAIL: begin
            if (!enable) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // State register and shared saturating timer, cleared on every state change
   always_ff @(posedge opt_gckn or negedge dlx_reset_n) begin
      if (!dlx_reset_n) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_state_next != r_state)
            r_timer <= '0;
         else if (r_timer != '1)
            r_timer <= r_timer + 1'b1;
      end
   end

   // Retry bookkeeping: attempt count and saturating retrain event counter
   always_ff @(posedge opt_gckn or negedge dlx_reset_n) begin
      if (!dlx_reset_n) begin
         r_attempt     <= '0;
         r_retrain_cnt <= '0;
      end else begin
         if (r_state == ST_IDLE || w_link_ok)
            r_attempt <= '0;
         else if (w_retry && !w_at_max)
            r_attempt <= r_attempt + 1'b1;
         if (w_retry && !w_at_max && r_retrain_cnt != 4'hF)
            r_retrain_cnt <= r_retrain_cnt + 1'b1;
      end
   end

   // Sequence flags: lanes synced, reset-done low seen, pulse abort request
   always_ff @(posedge opt_gckn or negedge dlx_reset_n) begin
      if (!dlx_reset_n) begin
         r_synced   <= 1'b0;
         r_seen_low <= 1'b0;
         r_abort    <= 1'b0;
      end else begin
         if (w_set_synced)      r_synced <= 1'b1;
         else if (w_clr_synced) r_synced <= 1'b0;
         if (r_state == ST_PULSE)
            r_seen_low <= 1'b0;
         else if (r_state == ST_WAIT_DONE && !rx_reset_done)
            r_seen_low <= 1'b1;
         if (r_state != ST_PULSE)
            r_abort <= 1'b0;
         else if (!enable)
            r_abort <= 1'b1;
      end
   end

   // Consecutive lane-invalid counter, only live in RUN
   always_ff @(posedge opt_gckn or negedge dlx_reset_n) begin
      if (!dlx_reset_n)
         r_loss <= '0;
      else if (r_state != ST_RUN || (&rx_valid))
         r_loss <= '0;
      else if (r_loss != '1)
         r_loss <= r_loss + 1'b1;
   end

   // Outputs registered from the next state so they align with the state register
   always_ff @(posedge opt_gckn or negedge dlx_reset_n) begin
      if (!dlx_reset_n) begin
         r_dp_reset  <= 1'b0;
         r_init_done <= '0;
         r_fail      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_dp_reset  <= (w_state_next == ST_PULSE);
         r_init_done <= (w_state_next == ST_RUN) ? {LANES{rx_reset_done}} : '0;
         r_fail      <= (w_state_next == ST_FAIL);
         r_busy      <= is_busy(w_state_next);
      end
   end

   assign rx_datapath_reset = r_dp_reset;
   assign rx_init_done      = r_init_done;
   assign retrain_cnt       = r_retrain_cnt;
   assign fail              = r_fail;
   assign busy              = r_busy;
   assign state             = r_state;

endmodule
